// File: rtl/ram_req_master.sv
// ram_req_master: request front end for a single-clock dual-port RAM.
//   Accepts a valid/ready stream of writes and reads, drives the RAM write
//   and read ports one cycle after acceptance, captures the registered RAM
//   read data and returns {addr, data} for reads through a response FIFO
//   in request order.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_wr/req_addr/req_wdata request payload (1 = write)
//   rsp_valid/rsp_ready       response handshake
//   rsp_addr/rsp_data         head-of-FIFO read response
//   ram_wr_*/ram_rd_*         RAM port connections (rd_data has 1-cycle latency)
//   rd_inflight               reads issued to the RAM but not yet buffered
module ram_req_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_wr_enbl,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enbl,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [2:0]            rd_inflight
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(RSP_DEPTH);

  // RAM port registers; rd_en_q doubles as the stage-1 read flag
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  // stage 2: RAM output valid this cycle, pushed into the FIFO at its end
  logic                  s2_q, s2_d;
  logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic          accept, push, pop, full;
  logic [CW:0]   used;

  // Credit counts both buffered and in-flight reads so a push can never
  // find the FIFO full.
  assign rd_inflight = {2'b00, rd_en_q} + {2'b00, s2_q};
  assign used        = {1'b0, count_q} + (CW+1)'(rd_inflight);
  assign req_ready   = !rst && (used < DEPTH_V);
  assign accept      = req_valid && req_ready;

  assign full      = (count_q == CW'(RSP_DEPTH));
  assign rsp_valid = (count_q != '0);
  assign push      = s2_q;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_addr  = fifo_addr_q[rptr_q];
  assign rsp_data  = fifo_data_q[rptr_q];

  assign ram_wr_enbl = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_enbl = rd_en_q;
  assign ram_rd_addr = rd_addr_q;

  always_comb begin
    wr_en_d   = accept && req_wr;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = accept && !req_wr;
    rd_addr_d = rd_addr_q;
    s2_d      = rd_en_q;
    s2_addr_d = s2_addr_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;

    if (accept && req_wr) begin
      wr_addr_d = req_addr;
      wr_data_d = req_wdata;
    end
    if (accept && !req_wr) begin
      rd_addr_d = req_addr;
    end
    if (rd_en_q) begin
      s2_addr_d = rd_addr_q;
    end

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      s2_q      <= 1'b0;
      s2_addr_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      s2_q      <= s2_d;
      s2_addr_q <= s2_addr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      if (push) begin
        fifo_addr_q[wptr_q] <= s2_addr_q;
        fifo_data_q[wptr_q] <= ram_rd_data;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_ram_req_master.sv
module tb_ram_req_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_wr;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_addr, rsp_data;
  logic       ram_wr_enbl, ram_rd_enbl;
  logic [7:0] ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_data;
  logic [2:0] rd_inflight;

  int fails  = 0;
  int checks = 0;
  int cyc    = 0;

  ram_req_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .ram_wr_enbl(ram_wr_enbl), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_enbl(ram_rd_enbl), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .rd_inflight(rd_inflight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port RAM environment: registered read, synchronous clear on rst.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram_rd_data <= 8'h00;
    end else begin
      if (ram_wr_enbl) ram[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_enbl) ram_rd_data <= ram[ram_rd_addr];
    end
  end

  // Reference model: memory image updated at accept time, expected
  // responses queued in request order.
  logic [7:0]  ref_mem [256];
  logic [15:0] expq [$];
  int          pop_cyc [$];
  bit          exp_wr, exp_rd, exp_rd2;
  logic [7:0]  exp_wa, exp_wd, exp_ra;

  bit rr_rand  = 1'b0;
  bit rr_fixed = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rsp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_fixed;
  end

  // Stimulus side: at each edge, record what the DUT accepts.
  always @(posedge clk) begin
    if (rst) begin
      exp_wr = 0; exp_rd = 0; exp_rd2 = 0;
    end else begin
      exp_rd2 = exp_rd;
      exp_wr  = req_valid && req_ready && req_wr;
      exp_rd  = req_valid && req_ready && !req_wr;
      if (exp_wr) begin
        ref_mem[req_addr] = req_wdata;
        exp_wa = req_addr;
        exp_wd = req_wdata;
      end
      if (exp_rd) begin
        expq.push_back({req_addr, ref_mem[req_addr]});
        exp_ra = req_addr;
      end
    end
  end

  // Monitor: checks port behaviour and pops the scoreboard.
  bit         hold_prev = 0;
  logic [7:0] hold_a, hold_d;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0;
    end else begin
      chk("req_ready", req_ready, (expq.size() < 4));
      chk("ram_wr_enbl", ram_wr_enbl, exp_wr);
      if (exp_wr) begin
        chk("ram_wr_addr", ram_wr_addr, exp_wa);
        chk("ram_wr_data", ram_wr_data, exp_wd);
      end
      chk("ram_rd_enbl", ram_rd_enbl, exp_rd);
      if (exp_rd) chk("ram_rd_addr", ram_rd_addr, exp_ra);
      chk("rd_inflight", rd_inflight, 32'(exp_rd) + 32'(exp_rd2));
      if (rsp_valid && hold_prev) begin
        chk("rsp_hold_addr", rsp_addr, hold_a);
        chk("rsp_hold_data", rsp_data, hold_d);
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          logic [15:0] e;
          e = expq.pop_front();
          chk("rsp_addr", rsp_addr, e[15:8]);
          chk("rsp_data", rsp_data, e[7:0]);
          pop_cyc.push_back(cyc);
        end
      end
      hold_prev = rsp_valid && !rsp_ready;
      hold_a = rsp_addr;
      hold_d = rsp_data;
    end
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int unsigned budget, output bit ok, output int unsigned waited);
    req_valid = 1; req_wr = w; req_addr = a; req_wdata = d;
    ok = 0; waited = 0;
    while (!ok && waited < budget) begin
      @(posedge clk);
      waited++;
      ok = req_ready;
    end
    #1;
    req_valid = 0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input bit v);
    rr_fixed = v;
    idle(2);
  endtask

  initial begin
    bit ok;
    int unsigned w, n;
    int base;

    rst = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_wr_enbl", ram_wr_enbl, 0);
    chk("reset_rd_enbl", ram_rd_enbl, 0);
    chk("reset_inflight", rd_inflight, 0);
    chk("reset_req_ready", req_ready, 0);
    rst = 0;

    // write then read same address next cycle; accept-to-valid latency
    send(1, 8'h10, 8'hA5, 10, ok, w);
    send(0, 8'h10, 8'h00, 10, ok, w);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    chk("rd_latency", n, 3);
    idle(4);

    // pre-write and 8 back-to-back reads with rsp_ready=1
    for (int unsigned i = 0; i < 8; i++) send(1, 8'(i), 8'(i) ^ 8'hFF, 10, ok, w);
    base = pop_cyc.size();
    for (int unsigned i = 0; i < 8; i++) begin
      send(0, 8'(i), 8'h00, 10, ok, w);
      chk("b2b_ready", w, 1);
    end
    idle(5);
    chk("b2b_count", pop_cyc.size() - base, 8);
    if (pop_cyc.size() - base == 8) chk("b2b_contig", pop_cyc[base+7] - pop_cyc[base], 7);

    // credit limit with rsp_ready=0
    set_ready(0);
    for (int unsigned i = 0; i < 4; i++) send(0, 8'(i), 8'h00, 10, ok, w);
    send(0, 8'h04, 8'h00, 6, ok, w);
    chk("credit_block", ok, 0);
    chk("full_inflight", rd_inflight, 0);
    chk("full_rsp_valid", rsp_valid, 1);
    chk("full_req_ready", req_ready, 0);
    base = pop_cyc.size();
    rr_fixed = 1;
    idle(8);
    chk("drain_count", pop_cyc.size() - base, 4);
    chk("reopen_ready", req_ready, 1);
    send(0, 8'h04, 8'h00, 10, ok, w);
    send(0, 8'h05, 8'h00, 10, ok, w);
    idle(5);

    // push/pop with entries buffered, mixed ops across pointer wrap
    set_ready(0);
    send(0, 8'h06, 8'h00, 10, ok, w);
    send(0, 8'h07, 8'h00, 10, ok, w);
    idle(3);
    rr_fixed = 1;
    for (int unsigned i = 0; i < 20; i++)
      send(i[0], 8'($urandom_range(0, 7)), 8'($urandom), 20, ok, w);
    idle(6);

    // write blocked at credit limit
    set_ready(0);
    for (int unsigned i = 0; i < 4; i++) send(0, 8'(i), 8'h00, 10, ok, w);
    send(1, 8'h30, 8'h5A, 6, ok, w);
    chk("write_blocked", ok, 0);
    rr_fixed = 1;
    send(1, 8'h30, 8'h5A, 20, ok, w);
    chk("write_unblocked", ok, 1);
    send(0, 8'h30, 8'h00, 20, ok, w);
    idle(6);

    // reset with 2 buffered and 2 in flight
    set_ready(0);
    for (int unsigned i = 0; i < 4; i++) send(0, 8'(8'h40 + i), 8'h00, 10, ok, w);
    chk("pre_rst_inflight", rd_inflight, 2);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    rst = 1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_enbl", ram_rd_enbl, 0);
    chk("rst_inflight", rd_inflight, 0);
    expq.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rr_fixed = 1;
    idle(2);
    rst = 0;
    idle(4);
    chk("no_stale_rsp", rsp_valid, 0);
    send(0, 8'h20, 8'h00, 10, ok, w);
    idle(5);

    // randomized mixed traffic with random backpressure
    rr_rand = 1;
    for (int unsigned i = 0; i < 200; i++) begin
      send($urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)), 8'($urandom), 60, ok, w);
      chk("rand_accept", ok, 1);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rr_rand = 0;
    rr_fixed = 1;
    idle(12);
    chk("final_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", fails, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
